// File: rtl/cm0_rst_pkg.sv
// ---------------------------------------------------------------------------
// cm0_rst_pkg
// Shared definitions for the Cortex-M0 reset sequencer:
//   - seq_state_e : sequencer state encodings (also exported on SEQ_STATE)
//   - RSTINFO_*   : bit positions of the sticky reset-cause register
// ---------------------------------------------------------------------------
package cm0_rst_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK  = 3'd0,
        ST_STRETCH    = 3'd1,
        ST_REL_PERIPH = 3'd2,
        ST_REL_CORE   = 3'd3,
        ST_RUN        = 3'd4,
        ST_WARM       = 3'd5
    } seq_state_e;

    localparam int unsigned RSTINFO_SYSREQ = 0;
    localparam int unsigned RSTINFO_WDOG   = 1;
    localparam int unsigned RSTINFO_LOCKUP = 2;

endpackage

// File: rtl/cm0_rst_sync.sv
// ---------------------------------------------------------------------------
// cm0_rst_sync
// Two-flop synchroniser for a single asynchronous level into the i_clk domain.
// Both flops clear to 0 asynchronously while i_rst_n is low.
// Ports:
//   i_clk   : destination clock
//   i_rst_n : asynchronous active-low clear
//   i_d     : asynchronous input
//   o_q     : synchronised output (follows i_d after two i_clk edges)
// ---------------------------------------------------------------------------
module cm0_rst_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/cm0_reset_sequencer.sv
// ---------------------------------------------------------------------------
// cm0_reset_sequencer
// Global reset / start-up sequencer for the Cortex-M0 MCU FPGA build.
// Waits for PLL lock, holds all resets for STRETCH_CYCLES, then releases
// PRESETn, HRESETn and IO_EN STAGGER_CYCLES apart. In RUN, core, watchdog
// and (optionally) lockup requests cause a warm reset and are recorded in
// the sticky RSTINFO register. Loss of PLL lock forces a cold restart.
//
// Build option: define LOCKUP_RESET_EN to make LOCKUP a warm-reset source
// (sets RSTINFO[2]); otherwise LOCKUP is ignored and RSTINFO[2] stays 0.
//
// Ports:
//   FCLK        : free-running clock
//   PORESETn    : power-on reset, asynchronous active-low
//   PLL_LOCKED  : asynchronous PLL lock, synchronised internally
//   SYSRESETREQ : core reset request
//   WDOGRES     : watchdog reset request
//   LOCKUP      : core lockup indication
//   RSTINFO_CLR : strobe, clears RSTINFO (a same-cycle set wins)
//   PRESETn     : peripheral reset, active-low
//   HRESETn     : core / AHB system reset, active-low
//   IO_EN       : pad output enable
//   RSTINFO     : sticky cause {LOCKUP, WDOGRES, SYSRESETREQ}
//   SEQ_STATE   : current state encoding for debug
// ---------------------------------------------------------------------------
module cm0_reset_sequencer
    import cm0_rst_pkg::*;
#(
    parameter int unsigned STRETCH_CYCLES = 16,
    parameter int unsigned STAGGER_CYCLES = 4
) (
    input  logic       FCLK,
    input  logic       PORESETn,
    input  logic       PLL_LOCKED,
    input  logic       SYSRESETREQ,
    input  logic       WDOGRES,
    input  logic       LOCKUP,
    input  logic       RSTINFO_CLR,
    output logic       PRESETn,
    output logic       HRESETn,
    output logic       IO_EN,
    output logic [2:0] RSTINFO,
    output logic [2:0] SEQ_STATE
);

    localparam int unsigned MAX_CYC = (STRETCH_CYCLES > STAGGER_CYCLES) ?
                                      STRETCH_CYCLES : STAGGER_CYCLES;
    localparam int unsigned CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] STRETCH_LD = CW'(STRETCH_CYCLES - 1);
    localparam logic [CW-1:0] STAGGER_LD = CW'(STAGGER_CYCLES - 1);

    seq_state_e      r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_presetn;
    logic            r_hresetn;
    logic            r_io_en;
    logic [2:0]      r_rstinfo;

    seq_state_e      w_next_state;
    logic [CW-1:0]   w_next_cnt;
    logic            w_lock_s;
    logic [2:0]      w_req_bits;
    logic [2:0]      w_set;
    logic            w_cnt_zero;

    cm0_rst_sync u_lock_sync (
        .i_clk   (FCLK),
        .i_rst_n (PORESETn),
        .i_d     (PLL_LOCKED),
        .o_q     (w_lock_s)
    );

    assign w_req_bits[RSTINFO_SYSREQ] = SYSRESETREQ;
    assign w_req_bits[RSTINFO_WDOG]   = WDOGRES;
`ifdef LOCKUP_RESET_EN
    assign w_req_bits[RSTINFO_LOCKUP] = LOCKUP;
`else
    logic w_unused_lockup;
    assign w_unused_lockup            = LOCKUP;
    assign w_req_bits[RSTINFO_LOCKUP] = 1'b0;
`endif

    // Causes are captured only while running, even if lock is lost on
    // the same edge (the cold restart then takes precedence for state).
    assign w_set      = (r_state == ST_RUN) ? w_req_bits : '0;
    assign w_cnt_zero = (r_cnt == '0);

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        if (!w_lock_s) begin
            w_next_state = ST_WAIT_LOCK;
            w_next_cnt   = '0;
        end else begin
            case (r_state)
                ST_WAIT_LOCK: begin
                    w_next_state = ST_STRETCH;
                    w_next_cnt   = STRETCH_LD;
                end
                ST_STRETCH, ST_WARM: begin
                    if (w_cnt_zero) begin
                        w_next_state = ST_REL_PERIPH;
                        w_next_cnt   = STAGGER_LD;
                    end else begin
                        w_next_cnt = r_cnt - CW'(1);
                    end
                end
                ST_REL_PERIPH: begin
                    if (w_cnt_zero) begin
                        w_next_state = ST_REL_CORE;
                        w_next_cnt   = STAGGER_LD;
                    end else begin
                        w_next_cnt = r_cnt - CW'(1);
                    end
                end
                ST_REL_CORE: begin
                    if (w_cnt_zero) begin
                        w_next_state = ST_RUN;
                    end else begin
                        w_next_cnt = r_cnt - CW'(1);
                    end
                end
                ST_RUN: begin
                    if (|w_req_bits) begin
                        w_next_state = ST_WARM;
                        w_next_cnt   = STRETCH_LD;
                    end
                end
                default: begin
                    w_next_state = ST_WAIT_LOCK;
                    w_next_cnt   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same
    // edge as the state. IO_EN, once set in RUN, survives warm sequences
    // and drops only on a return to WAIT_LOCK.
    always_ff @(posedge FCLK or negedge PORESETn) begin
        if (!PORESETn) begin
            r_state   <= ST_WAIT_LOCK;
            r_cnt     <= '0;
            r_presetn <= 1'b0;
            r_hresetn <= 1'b0;
            r_io_en   <= 1'b0;
            r_rstinfo <= '0;
        end else begin
            r_state   <= w_next_state;
            r_cnt     <= w_next_cnt;
            r_presetn <= (w_next_state == ST_REL_PERIPH) ||
                         (w_next_state == ST_REL_CORE)   ||
                         (w_next_state == ST_RUN);
            r_hresetn <= (w_next_state == ST_REL_CORE) ||
                         (w_next_state == ST_RUN);
            r_io_en   <= (w_next_state == ST_RUN) ||
                         (r_io_en && (w_next_state != ST_WAIT_LOCK));
            r_rstinfo <= (RSTINFO_CLR ? 3'b000 : r_rstinfo) | w_set;
        end
    end

    assign PRESETn   = r_presetn;
    assign HRESETn   = r_hresetn;
    assign IO_EN     = r_io_en;
    assign RSTINFO   = r_rstinfo;
    assign SEQ_STATE = r_state;

endmodule

// File: tb/tb_cm0_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cm0_reset_sequencer
// Scoreboard bench: the driver applies inputs, advances a timeline model of
// the sequencer (outputs derived from the edge count since the sequence
// origin) and queues the expected outputs; a monitor pops and compares one
// entry per clock.
// ---------------------------------------------------------------------------
module tb_cm0_reset_sequencer;

    localparam int S = 16;
    localparam int G = 4;

    logic       FCLK = 1'b0;
    logic       PORESETn = 1'b0;
    logic       PLL_LOCKED = 1'b0;
    logic       SYSRESETREQ = 1'b0;
    logic       WDOGRES = 1'b0;
    logic       LOCKUP = 1'b0;
    logic       RSTINFO_CLR = 1'b0;
    logic       PRESETn;
    logic       HRESETn;
    logic       IO_EN;
    logic [2:0] RSTINFO;
    logic [2:0] SEQ_STATE;

    cm0_reset_sequencer #(
        .STRETCH_CYCLES (S),
        .STAGGER_CYCLES (G)
    ) dut (
        .FCLK        (FCLK),
        .PORESETn    (PORESETn),
        .PLL_LOCKED  (PLL_LOCKED),
        .SYSRESETREQ (SYSRESETREQ),
        .WDOGRES     (WDOGRES),
        .LOCKUP      (LOCKUP),
        .RSTINFO_CLR (RSTINFO_CLR),
        .PRESETn     (PRESETn),
        .HRESETn     (HRESETn),
        .IO_EN       (IO_EN),
        .RSTINFO     (RSTINFO),
        .SEQ_STATE   (SEQ_STATE)
    );

    always #5 FCLK = ~FCLK;

`ifdef LOCKUP_RESET_EN
    localparam bit LOCKUP_EN = 1'b1;
`else
    localparam bit LOCKUP_EN = 1'b0;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Expected vector: {PRESETn, HRESETn, IO_EN, RSTINFO[2:0], SEQ_STATE[2:0]}
    logic [8:0] exp_q[$];

    // Timeline model
    int   m_edge;
    bit   m_ls1, m_ls2;
    bit   m_seq;
    bit   m_warm;
    int   m_origin;
    logic [2:0] m_info;

    function automatic logic [8:0] dut_vec();
        return {PRESETn, HRESETn, IO_EN, RSTINFO, SEQ_STATE};
    endfunction

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t: got P=%b H=%b IO=%b INFO=%b ST=%0d, expected P=%b H=%b IO=%b INFO=%b ST=%0d",
                     name, $time, act[8], act[7], act[6], act[5:3], act[2:0],
                     exp[8], exp[7], exp[6], exp[5:3], exp[2:0]);
        end
    endtask

    task automatic model_reset();
        m_edge = 0; m_ls1 = 0; m_ls2 = 0;
        m_seq = 0; m_warm = 0; m_origin = 0; m_info = 3'b000;
    endtask

    task automatic model_edge(input bit lk, input bit sr, input bit wd, input bit lu, input bit cl);
        bit         old_ls;
        bit         running;
        logic [2:0] bits;
        m_edge++;
        old_ls  = m_ls2;
        m_ls2   = m_ls1;
        m_ls1   = lk;
        running = m_seq && ((m_edge - 1 - m_origin) >= S + 2 * G);
        bits    = running ? {lu & LOCKUP_EN, wd, sr} : 3'b000;
        m_info  = (cl ? 3'b000 : m_info) | bits;
        if (!m_seq) begin
            if (old_ls) begin
                m_seq = 1; m_origin = m_edge; m_warm = 0;
            end
        end else if (!old_ls) begin
            m_seq = 0;
        end else if (bits != 3'b000) begin
            m_origin = m_edge; m_warm = 1;
        end
    endtask

    function automatic logic [8:0] model_expect();
        int e;
        logic p, h, io;
        logic [2:0] st;
        if (!m_seq) return {3'b000, m_info, 3'd0};
        e  = m_edge - m_origin;
        p  = (e >= S);
        h  = (e >= S + G);
        io = m_warm || (e >= S + 2 * G);
        if (e < S)              st = m_warm ? 3'd5 : 3'd1;
        else if (e < S + G)     st = 3'd2;
        else if (e < S + 2 * G) st = 3'd3;
        else                    st = 3'd4;
        return {p, h, io, m_info, st};
    endfunction

    task automatic step(input bit por, input bit lk, input bit sr, input bit wd,
                        input bit lu, input bit cl);
        @(negedge FCLK);
        PORESETn = por; PLL_LOCKED = lk; SYSRESETREQ = sr;
        WDOGRES = wd; LOCKUP = lu; RSTINFO_CLR = cl;
        @(posedge FCLK);
        if (por) model_edge(lk, sr, wd, lu, cl);
        else     model_reset();
        exp_q.push_back(model_expect());
    endtask

    task automatic idle(input int n, input bit lk);
        for (int i = 0; i < n; i++) step(1, lk, 0, 0, 0, 0);
    endtask

    task automatic por_now();
        @(negedge FCLK);
        PORESETn = 1'b0;
        model_reset();
        #1;
        check("por_async_clear", dut_vec(), model_expect());
    endtask

    // Monitor: one comparison per clock, away from the active edge.
    initial begin
        forever begin
            @(posedge FCLK);
            #1;
            if (exp_q.size() > 0) check("scoreboard", dut_vec(), exp_q.pop_front());
        end
    end

    initial begin
        bit lk;
        model_reset();

        // Cold start with lock already high.
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
        idle(32, 1);

        // Single-cycle SYSRESETREQ in RUN.
        step(1, 1, 1, 0, 0, 0);
        idle(28, 1);

        // WDOGRES with simultaneous clear, then a lone clear.
        step(1, 1, 0, 1, 0, 1);
        idle(28, 1);
        step(1, 1, 0, 0, 0, 1);
        idle(3, 1);

        // LOCKUP in RUN.
        step(1, 1, 0, 0, 1, 0);
        idle(28, 1);

        // Warm reset, then lock loss around REL_CORE, then lock return.
        step(1, 1, 1, 0, 0, 0);
        idle(21, 1);
        idle(6, 0);
        idle(40, 1);

        // Async POR mid-STRETCH after a relock.
        idle(5, 0);
        idle(10, 1);
        por_now();
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);

        // Lock arrives 50 cycles after release.
        idle(50, 0);
        idle(35, 1);

        // Randomized traffic.
        lk = 1;
        for (int i = 0; i < 3000; i++) begin
            if (lk && $urandom_range(0, 399) == 0) lk = 0;
            else if (!lk && $urandom_range(0, 7) == 0) lk = 1;
            step(1, lk,
                 $urandom_range(0, 39) == 0,
                 $urandom_range(0, 59) == 0,
                 $urandom_range(0, 79) == 0,
                 $urandom_range(0, 29) == 0);
        end

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge FCLK);
        #2;
        if (exp_q.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cm0_reset_sequencer.md
# cm0_reset_sequencer

Global reset and start-up sequencer for the Cortex-M0 MCU FPGA build. It waits for PLL lock after power-on reset, holds all resets for a stretch period, then releases the peripheral reset, the system reset and the I/O output enable in a fixed staggered order. After start-up it converts core, watchdog and lockup reset requests into warm resets and records the cause in sticky status bits. It sits between the board reset/PLL and the core, bus fabric and peripherals, and is the only source of HRESETn and PRESETn.

## Interface
- STRETCH_CYCLES, 16: cycles all resets stay asserted after lock, or after a warm-reset request; must be ≥1.
- STAGGER_CYCLES, 4: cycles between successive releases; must be ≥1.
- FCLK  in  1  free-running clock.
- PORESETn  in  1  power-on reset; one clock; reset is asynchronous and active-low.
- PLL_LOCKED  in  1  asynchronous PLL lock; synchronised internally.
- SYSRESETREQ  in  1  core reset request, FCLK domain, level or pulse.
- WDOGRES  in  1  watchdog reset request, FCLK domain.
- LOCKUP  in  1  core lockup indication, FCLK domain.
- RSTINFO_CLR  in  1  single-cycle strobe; clears RSTINFO.
- PRESETn  out  1  peripheral reset, active-low.
- HRESETn  out  1  core and AHB system reset, active-low.
- IO_EN  out  1  pad output enable; 0 = outputs tristated.
- RSTINFO  out  3  sticky cause: [0] SYSRESETREQ, [1] WDOGRES, [2] LOCKUP.
- SEQ_STATE  out  3  current state encoding, for debug.

## Operation
- States: WAIT_LOCK(0), STRETCH(1), REL_PERIPH(2), REL_CORE(3), RUN(4), WARM(5).
- PORESETn low clears asynchronously:
  - state = WAIT_LOCK, counter = 0, lock synchroniser = 0;
  - PRESETn = 0, HRESETn = 0, IO_EN = 0, RSTINFO = 0.
- Outputs are registered and decoded from the next state, so each output changes on the same edge the state changes. PRESETn, HRESETn and IO_EN are glitch-free.
- WAIT_LOCK: all outputs 0. Go to STRETCH on the first edge where the synchronised lock (lock_s) is 1.
- STRETCH:
  - On entry, load counter with STRETCH_CYCLES-1; decrement each cycle.
  - At 0, go to REL_PERIPH (PRESETn=1) and load STAGGER_CYCLES-1.
- REL_PERIPH: at 0, go to REL_CORE (HRESETn=1) and reload STAGGER_CYCLES-1.
- REL_CORE: at 0, go to RUN (IO_EN=1).
- RUN:
  - Warm request = SYSRESETREQ | WDOGRES | (LOCKUP if enabled).
  - On a request, go to WARM: PRESETn=0 and HRESETn=0 next edge, IO_EN stays 1, load STRETCH_CYCLES-1.
  - All asserted request bits are ORed into RSTINFO on that edge.
- WARM: at 0, go to REL_PERIPH; the release sequence then repeats, and IO_EN stays 1.
- Requests in any state other than RUN are ignored and not recorded.
- Lock loss: lock_s=0 in any state except WAIT_LOCK forces WAIT_LOCK next edge, with all three outputs 0 (cold sequence). RSTINFO is retained.
- RSTINFO_CLR clears all bits. If a set and a clear occur in the same cycle, the set wins.
- Lock loss and a warm request in the same cycle: lock loss wins, and the cause is still recorded.

## Timing
- Lock synchroniser: 2 flops; lock_s follows PLL_LOCKED after 2 FCLK edges.
- PORESETn released with PLL_LOCKED high, edges counted from the first rising FCLK after release:
  - lock_s = 1 at edge 2; STRETCH entered at edge 3;
  - PRESETn rises at edge 3+STRETCH_CYCLES (19 at defaults);
  - HRESETn rises at +STAGGER_CYCLES (23);
  - IO_EN rises at +STAGGER_CYCLES (27).
- Warm reset: resets assert 1 edge after the request is sampled. PRESETn rises STRETCH_CYCLES edges later; HRESETn rises STAGGER_CYCLES after that.
- Counter width: $clog2(max(STRETCH_CYCLES, STAGGER_CYCLES)+1), unsigned, no wrap. Reload occurs only on state entry.

## Configuration
- LOCKUP_RESET_EN defined: LOCKUP in RUN is a warm-reset request and sets RSTINFO[2].
- LOCKUP_RESET_EN undefined: LOCKUP is ignored and RSTINFO[2] is tied to 0.

## Structure
- Package cm0_rst_pkg holds:
  - the state enum and its 3-bit encodings;
  - the RSTINFO bit index constants.
- Sub-module cm0_rst_sync: 2-flop synchroniser, async active-low clear to 0, instantiated for PLL_LOCKED.

## Test plan
- Cold start, lock high at release: PRESETn/HRESETn/IO_EN rise at edges 19/23/27 at defaults; SEQ_STATE steps 0,1,2,3,4.
- Lock rises 50 cycles after release: the outputs stay 0 until 2 edges after lock, then follow the same 16/4/4 spacing.
- One-cycle SYSRESETREQ pulse in RUN: PRESETn and HRESETn fall next edge while IO_EN stays 1; RSTINFO=3'b001; PRESETn rises 16 edges later and HRESETn 4 after that.
- WDOGRES and RSTINFO_CLR in the same cycle: RSTINFO=3'b010. A later lone RSTINFO_CLR gives RSTINFO=0.
- LOCKUP in RUN:
  - with LOCKUP_RESET_EN defined: warm reset and RSTINFO=3'b100;
  - without it: no reset and RSTINFO=0.
- PLL_LOCKED drops during REL_CORE: all outputs 0 within 3 edges, state 0, and the full cold sequence restarts when lock returns. PORESETn asserted mid-STRETCH clears everything immediately.
